// File: rtl/grid_mem_pkg.sv
// Shared constants and types for the grid bank responder and its arbiter.
package grid_mem_pkg;

  // Default geometry: 8-bit chunks, 64-bit rows, 16 rows per bank.
  localparam int N_CLIENTS_DEF = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int ROW_BITS_DEF  = 64;
  localparam int DEPTH_DEF     = 16;
  localparam int ADDR_W_DEF    = 5;
  localparam int COL_W_DEF     = 6;

  // Chunks per row, and the shift that turns a bit offset into a chunk index.
  localparam int WORDS_PER_ROW = ROW_BITS_DEF / DATA_W_DEF;
  localparam int DATA_SHIFT    = $clog2(DATA_W_DEF);

  // Width of a client grant index.
  localparam int GID_W = (N_CLIENTS_DEF > 1) ? $clog2(N_CLIENTS_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Owner of the transaction in flight: the host, or the indexed client.
  typedef struct packed {
    logic             host;
    logic [GID_W-1:0] id;
  } grant_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W-1:0] slot;

  // Walk the clients starting at the pointer and take the first one asking.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = PTR_W'((int'(ptr) + k) % N);
      if (!valid && req[slot]) begin
        grant[slot] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_bank_responder.sv
// Memory-side responder for one grid bank: host port plus round-robin
// clients, three-cycle IDLE -> ACCESS -> ACK handshake per transaction.
//
// state  | meaning
// IDLE   | sample host/client requests, latch the winner's operation
// ACCESS | perform the bank read or write, load the ack and read data
// ACK    | ack pulse visible; advance the round-robin pointer on client grants
module grid_bank_responder
  import grid_mem_pkg::*;
#(
  parameter int N_CLIENTS = N_CLIENTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROW_BITS  = ROW_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int COL_W     = COL_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CLIENTS-1:0]        cl_read_en,
  input  logic [N_CLIENTS-1:0]        cl_write_en,
  input  logic [N_CLIENTS*ADDR_W-1:0] cl_row_addr,
  input  logic [N_CLIENTS*COL_W-1:0]  cl_col_addr,
  input  logic [N_CLIENTS*DATA_W-1:0] cl_wdata,
  output logic [N_CLIENTS-1:0]        cl_ack,
  output logic [DATA_W-1:0]           cl_rdata,
  input  logic                        host_en,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_row,
  input  logic [COL_W-1:0]            host_col,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_ack,
  output logic [DATA_W-1:0]           host_rdata,
  output logic                        busy
);

  localparam int WPR    = ROW_BITS / DATA_W;
  localparam int SHIFT  = $clog2(DATA_W);
  localparam int NWORDS = DEPTH * WPR;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t state;
  grant_t grant;
  logic [GID_W-1:0] rr_ptr;

  logic [N_CLIENTS-1:0] cl_req;
  logic [N_CLIENTS-1:0] arb_grant;
  logic                 arb_valid;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_row;
  logic [COL_W-1:0]  sel_col;
  logic [DATA_W-1:0] sel_wdata;
  logic [GID_W-1:0]  sel_id;

  logic              op_we;
  logic [ADDR_W-1:0] op_row;
  logic [COL_W-1:0]  op_col;
  logic [DATA_W-1:0] op_wdata;

  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [NWORDS];

  // A simultaneous read and write request is treated as a write.
  assign cl_req = cl_read_en | cl_write_en;
  assign busy   = (state != IDLE);

  rr_arbiter #(
    .N     (N_CLIENTS),
    .PTR_W (GID_W)
  ) u_arb (
    .req   (cl_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Pick the operation to latch: host first, otherwise the arbiter winner.
  always_comb begin
    sel_we    = 1'b0;
    sel_row   = '0;
    sel_col   = '0;
    sel_wdata = '0;
    sel_id    = '0;
    if (host_en) begin
      sel_we    = host_we;
      sel_row   = host_row;
      sel_col   = host_col;
      sel_wdata = host_wdata;
    end else begin
      for (int k = 0; k < N_CLIENTS; k++) begin
        if (arb_grant[k]) begin
          sel_we    = cl_write_en[k];
          sel_row   = cl_row_addr[k*ADDR_W +: ADDR_W];
          sel_col   = cl_col_addr[k*COL_W +: COL_W];
          sel_wdata = cl_wdata[k*DATA_W +: DATA_W];
          sel_id    = GID_W'(k);
        end
      end
    end
  end

  // Latch the granted operation while idle; held through ACCESS and ACK.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      op_we      <= sel_we;
      op_row     <= sel_row;
      op_col     <= sel_col;
      op_wdata   <= sel_wdata;
      grant.host <= host_en;
      grant.id   <= sel_id;
    end
  end

  // Word address; the low column bits below chunk granularity are dropped.
  always_comb begin
    in_range = (int'(op_row) < DEPTH);
    word_idx = IDX_W'(int'(op_row) * WPR + int'(op_col >> SHIFT));
  end

  // Out-of-range rows read back as zero.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[word_idx];
  end

  // Bank storage: written in ACCESS, never cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && op_we && in_range) begin
      mem[word_idx] <= op_wdata;
    end
  end

  // Handshake FSM with registered ack pulses and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cl_ack     <= '0;
      host_ack   <= 1'b0;
      cl_rdata   <= '0;
      host_rdata <= '0;
      rr_ptr     <= '0;
    end else begin
      cl_ack   <= '0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (host_en || arb_valid) state <= ACCESS;
        end
        ACCESS: begin
          state <= ACK;
          if (grant.host) begin
            host_ack <= 1'b1;
            if (!op_we) host_rdata <= rd_word;
          end else begin
            cl_ack[grant.id] <= 1'b1;
            if (!op_we) cl_rdata <= rd_word;
          end
        end
        ACK: begin
          state <= IDLE;
          if (!grant.host) begin
            if (grant.id == GID_W'(N_CLIENTS - 1)) rr_ptr <= '0;
            else                                  rr_ptr <= grant.id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_bank_responder.sv
// Directed self-checking bench for grid_bank_responder (default geometry:
// 4 clients, 8-bit chunks, 64-bit rows, 16 rows).
module tb_grid_bank_responder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  cl_read_en;
  logic [N-1:0]  cl_write_en;
  logic [N*AW-1:0] cl_row_addr;
  logic [N*CW-1:0] cl_col_addr;
  logic [N*DW-1:0] cl_wdata;
  logic [N-1:0]  cl_ack;
  logic [DW-1:0] cl_rdata;
  logic          host_en;
  logic          host_we;
  logic [AW-1:0] host_row;
  logic [CW-1:0] host_col;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  grid_bank_responder dut (
    .clock       (clock),
    .reset       (reset),
    .cl_read_en  (cl_read_en),
    .cl_write_en (cl_write_en),
    .cl_row_addr (cl_row_addr),
    .cl_col_addr (cl_col_addr),
    .cl_wdata    (cl_wdata),
    .cl_ack      (cl_ack),
    .cl_rdata    (cl_rdata),
    .host_en     (host_en),
    .host_we     (host_we),
    .host_row    (host_row),
    .host_col    (host_col),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Host transaction; returns cycles to ack and the read data seen with it.
  task automatic host_xfer(input logic we, input logic [AW-1:0] row, input logic [CW-1:0] col,
                           input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                           output logic [N-1:0] cl_seen);
    host_en = 1'b1; host_we = we; host_row = row; host_col = col; host_wdata = wd;
    lat = 0;
    rd = '0;
    cl_seen = '0;
    while (lat < 12) begin
      tick();
      lat++;
      if (host_ack) break;
    end
    rd = host_rdata;
    cl_seen = cl_ack;
    host_en = 1'b0; host_we = 1'b0;
    tick();
  endtask

  // Client transaction; request held until the ack is seen.
  task automatic cl_xfer(input int id, input logic re, input logic we, input logic [AW-1:0] row,
                         input logic [CW-1:0] col, input logic [DW-1:0] wd,
                         output int lat, output logic [N-1:0] ackv, output logic [DW-1:0] rd);
    cl_read_en[id] = re;
    cl_write_en[id] = we;
    cl_row_addr[id*AW +: AW] = row;
    cl_col_addr[id*CW +: CW] = col;
    cl_wdata[id*DW +: DW] = wd;
    lat = 0;
    ackv = '0;
    rd = '0;
    while (lat < 12) begin
      tick();
      lat++;
      if (cl_ack != '0) break;
    end
    ackv = cl_ack;
    rd = cl_rdata;
    cl_read_en[id] = 1'b0;
    cl_write_en[id] = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    logic [DW-1:0] rd;
    logic [N-1:0] ackv;
    logic [N-1:0] exp_ack;

    reset = 1'b1;
    cl_read_en = '0; cl_write_en = '0;
    cl_row_addr = '0; cl_col_addr = '0; cl_wdata = '0;
    host_en = 1'b0; host_we = 1'b0; host_row = '0; host_col = '0; host_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_cl_ack", 32'(cl_ack), 32'h0);
    check("rst_host_ack", 32'(host_ack), 32'h0);
    check("rst_cl_rdata", 32'(cl_rdata), 32'h0);
    check("rst_host_rdata", 32'(host_rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Host load then readback of row 3, bit offset 8.
    host_xfer(1'b1, 5'd3, 6'd8, 8'hA5, lat, rd, ackv);
    check("host_wr_lat", 32'(lat), 32'd2);
    check("host_wr_rdata_kept", 32'(rd), 32'h0);
    host_xfer(1'b0, 5'd3, 6'd8, 8'h00, lat, rd, ackv);
    check("host_rd_lat", 32'(lat), 32'd2);
    check("host_rd_data", 32'(rd), 32'hA5);
    check("host_rd_no_cl_ack", 32'(ackv), 32'h0);

    // Client 1 reads the host-loaded word.
    cl_xfer(1, 1'b1, 1'b0, 5'd3, 6'd8, 8'h00, lat, ackv, rd);
    check("c1_rd_lat", 32'(lat), 32'd2);
    check("c1_rd_ack", 32'(ackv), 32'h2);
    check("c1_rd_data", 32'(rd), 32'hA5);
    check("c1_idle_after", 32'(busy), 32'h0);

    // Client 2 read+write together: write wins. Row 5 col 17 -> chunk 2.
    cl_xfer(2, 1'b1, 1'b1, 5'd5, 6'd17, 8'h3C, lat, ackv, rd);
    check("c2_rw_ack", 32'(ackv), 32'h4);
    check("c2_rw_rdata_kept", 32'(rd), 32'hA5);
    cl_xfer(2, 1'b1, 1'b0, 5'd5, 6'd16, 8'h00, lat, ackv, rd);
    check("c2_rd_data", 32'(rd), 32'h3C);
    cl_xfer(2, 1'b1, 1'b0, 5'd5, 6'd23, 8'h00, lat, ackv, rd);
    check("c2_unaligned_rd", 32'(rd), 32'h3C);
    host_xfer(1'b0, 5'd5, 6'd16, 8'h00, lat, rd, ackv);
    check("host_sees_c2", 32'(rd), 32'h3C);
    cl_xfer(2, 1'b1, 1'b0, 5'd5, 6'd8, 8'h00, lat, ackv, rd);
    check("c2_neighbor_rd", 32'(rd), 32'h00);

    // Out-of-range rows: read gives 0, write is acked and dropped.
    cl_xfer(0, 1'b0, 1'b1, 5'd0, 6'd0, 8'h5A, lat, ackv, rd);
    check("c0_wr_row0_ack", 32'(ackv), 32'h1);
    cl_xfer(0, 1'b1, 1'b0, 5'd3, 6'd8, 8'h00, lat, ackv, rd);
    check("c0_prime_rdata", 32'(rd), 32'hA5);
    cl_xfer(0, 1'b1, 1'b0, 5'd16, 6'd0, 8'h00, lat, ackv, rd);
    check("oor_rd_lat", 32'(lat), 32'd2);
    check("oor_rd_ack", 32'(ackv), 32'h1);
    check("oor_rd_data", 32'(rd), 32'h0);
    cl_xfer(0, 1'b0, 1'b1, 5'd16, 6'd0, 8'hFF, lat, ackv, rd);
    check("oor_wr_ack", 32'(ackv), 32'h1);
    cl_xfer(0, 1'b1, 1'b0, 5'd0, 6'd0, 8'h00, lat, ackv, rd);
    check("oor_wr_dropped", 32'(rd), 32'h5A);
    cl_xfer(0, 1'b1, 1'b0, 5'd31, 6'd63, 8'h00, lat, ackv, rd);
    check("oor_max_rd", 32'(rd), 32'h0);

    // Host and client 0 in the same IDLE cycle: host first.
    host_en = 1'b1; host_we = 1'b0; host_row = 5'd3; host_col = 6'd8;
    cl_read_en[0] = 1'b1; cl_row_addr[0 +: AW] = 5'd0; cl_col_addr[0 +: CW] = 6'd0;
    tick();
    tick();
    check("prio_host_ack", 32'(host_ack), 32'h1);
    check("prio_cl_wait", 32'(cl_ack), 32'h0);
    check("prio_host_data", 32'(host_rdata), 32'hA5);
    host_en = 1'b0;
    tick();
    check("prio_gap1", 32'(cl_ack), 32'h0);
    tick();
    check("prio_gap2", 32'(cl_ack), 32'h0);
    tick();
    check("prio_cl_ack", 32'(cl_ack), 32'h1);
    check("prio_cl_data", 32'(cl_rdata), 32'h5A);
    cl_read_en[0] = 1'b0;
    tick();

    // Reset while in ACCESS discards the pending ack.
    cl_read_en[3] = 1'b1; cl_row_addr[3*AW +: AW] = 5'd3; cl_col_addr[3*CW +: CW] = 6'd8;
    tick();
    check("rstmid_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_no_ack", 32'(cl_ack), 32'h0);
    check("rstmid_rdata_cleared", 32'(cl_rdata), 32'h0);
    cl_read_en[3] = 1'b0;
    reset = 1'b0;
    tick();
    check("rstmid_no_late_ack", 32'(cl_ack), 32'h0);

    // All clients reading continuously from a fresh pointer: 0,1,2,3,0.
    for (int k = 0; k < N; k++) begin
      cl_row_addr[k*AW +: AW] = 5'd3;
      cl_col_addr[k*CW +: CW] = 6'd8;
    end
    cl_read_en = '1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_ack = (c % 3 == 2) ? N'(1 << ((c / 3) % N)) : '0;
      check($sformatf("rr_cycle%0d", c), 32'(cl_ack), 32'(exp_ack));
    end
    check("rr_data", 32'(cl_rdata), 32'hA5);
    cl_read_en = '0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
